system_mutex_bank: RTL and testbench
====================================

SYSTEM_MUTEX_BANK -- requirements
Module: system_mutex_bank

Interface
REQ-001 The block SHALL take these parameters, one per line:
- NUM_MUTEX, 4, number of independent mutexes, 1..32.
- ADDR_W, 3, word-address width; 2^ADDR_W SHALL be >= NUM_MUTEX+4.
- LEASE_CYCLES, 0, auto-release timeout in clk cycles; 0 disables timeouts.
- INIT_OWNER, 0, 16-bit owner field loaded at reset.
- INIT_VALUE, 0, 16-bit value field loaded at reset.
REQ-002 The block SHALL have these ports, one per line:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- address, input, ADDR_W, word address.
- chipselect, input, 1, slave select.
- read, input, 1, read strobe.
- write, input, 1, write strobe.
- data_from_cpu, input, 32, write data: [31:16] owner, [15:0] value.
- data_to_cpu, output, 32, registered read data.
- irq, output, 1, release interrupt, level-sensitive.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-004 The address map SHALL be:
- 0..NUM_MUTEX-1: MUTEX[i], with {owner[15:0], value[15:0]}.
- NUM_MUTEX: RST_FLAG, bit0 only.
- NUM_MUTEX+1: LOCKED bitmap, read-only.
- NUM_MUTEX+2: IRQ_EN, read/write.
- NUM_MUTEX+3: IRQ_PEND, write-1-to-clear.
- All other addresses: reads return 0; writes are ignored.
REQ-005 A write to MUTEX[i] SHALL be accepted only if value_i==0 or owner_i==data_from_cpu[31:16]. An accepted write SHALL load both owner and value on the next edge. A rejected write SHALL leave the mutex unchanged.
REQ-006 A mutex SHALL be "locked" when value_i!=0. LOCKED bit i SHALL equal (value_i!=0); bits NUM_MUTEX..31 SHALL read 0.
REQ-007 A release event SHALL occur on either of:
- an accepted write with data_from_cpu[15:0]==0 while value_i!=0;
- a lease expiry (REQ-009).
A release event SHALL set IRQ_PEND bit i on the same edge.
REQ-008 If LEASE_CYCLES>0, each mutex SHALL keep a lease counter of width clog2(LEASE_CYCLES+1). The counter SHALL:
- clear on any accepted write to MUTEX[i];
- increment each cycle while locked;
- hold at 0 while unlocked.
REQ-009 Lease expiry: when the counter equals LEASE_CYCLES-1 and mutex i is locked with no accepted write in that cycle, owner_i and value_i SHALL become 0 on the next edge. The mutex therefore frees exactly LEASE_CYCLES edges after the last accepted write. With LEASE_CYCLES==0, no expiry SHALL ever occur.
REQ-010 An accepted write in the same cycle as an expiry SHALL take precedence: the written data is loaded and the counter clears.
REQ-011 RST_FLAG SHALL be 1 after reset and SHALL clear to 0 on any write to its address, regardless of data. It SHALL never set again except by reset.
REQ-012 IRQ_EN SHALL be NUM_MUTEX bits wide, fully read/write; upper bits SHALL read 0.
REQ-013 A write to IRQ_PEND SHALL clear the bits where data is 1. If a release event for bit i coincides with a clearing write, bit i SHALL end set (set wins).
REQ-014 irq SHALL be registered and equal |(IRQ_PEND & IRQ_EN) one cycle after either register changes.
REQ-015 Reads SHALL have fixed latency 1:
- chipselect&read at edge N SHALL present the addressed register's pre-edge-N contents on data_to_cpu after edge N.
- data_to_cpu SHALL hold its value when no read occurs.
REQ-016 Simultaneous read and write to the same address SHALL return the old value.
REQ-017 Strobes with chipselect low SHALL have no effect.

Reset
REQ-018 On reset, the block SHALL load:
- every owner_i to INIT_OWNER and every value_i to INIT_VALUE;
- all lease counters to 0;
- RST_FLAG to 1;
- IRQ_EN, IRQ_PEND, irq and data_to_cpu to 0.
REQ-019 Reset SHALL override any concurrent access, including a mid-lease count and pending interrupts.

Verification
REQ-020 Lock/contend: write MUTEX[1]=0x00AA0001, then 0x00BB0001. Required: MUTEX[1] reads 0x00AA0001; LOCKED reads 0x2.
REQ-021 Release irq: IRQ_EN=0x2; owner writes MUTEX[1]=0x00AA0000. Required: IRQ_PEND=0x2; irq=1 one cycle later. Writing IRQ_PEND=0x2 gives irq=0.
REQ-022 Lease (LEASE_CYCLES=8): lock MUTEX[0]=0x00110005 and stay idle. Required: MUTEX[0] reads 0 from the 8th edge after the write; IRQ_PEND bit0=1. An owner re-write on cycle 7 keeps the mutex locked.
REQ-023 Collisions: expiry coincides with an owner write, so the write wins; a release coincides with a W1C of the same bit, so the bit stays 1.
REQ-024 Boot: after reset, RST_FLAG=1; write RST_FLAG with any data gives 0. Reads of the unmapped address 2^ADDR_W-1 return 0x00000000.
REQ-025 Reset mid-operation: assert reset with 3 mutexes locked and irq=1. Required: all registers return to REQ-018 values on the next edge.

Source files
------------

// File: rtl/system_mutex_bank.sv
// system_mutex_bank
//   A bank of NUM_MUTEX hardware mutexes on a simple word-addressed slave port.
//   Each mutex holds {owner[15:0], value[15:0]}; it is locked while value != 0,
//   and only its current owner may change it while locked. An optional lease
//   auto-releases a mutex LEASE_CYCLES edges after its last accepted write.
//   Releases raise bits in IRQ_PEND, which are masked by IRQ_EN to drive irq.
//
// Handshake: there is no valid/ready; chipselect&read or chipselect&write is a
//   single-cycle access taken on the rising edge. Reads return the pre-edge
//   register contents on data_to_cpu after that edge (latency 1) and
//   data_to_cpu holds between reads. Strobes without chipselect do nothing.
//
// Ports
//   clk            sole clock
//   reset          synchronous, active-high
//   address        word address (mutexes, RST_FLAG, LOCKED, IRQ_EN, IRQ_PEND)
//   chipselect     slave select
//   read / write   access strobes
//   data_from_cpu  write data: [31:16] owner, [15:0] value
//   data_to_cpu    registered read data
//   irq            registered |(IRQ_PEND & IRQ_EN), level-sensitive
module system_mutex_bank #(
  parameter int          NUM_MUTEX    = 4,
  parameter int          ADDR_W       = 3,
  parameter int          LEASE_CYCLES = 0,
  parameter logic [15:0] INIT_OWNER   = 16'h0000,
  parameter logic [15:0] INIT_VALUE   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data_to_cpu,
  output logic              irq
);

  // A one-bit dummy counter keeps the declarations legal when leases are off.
  localparam int               CNT_W      = (LEASE_CYCLES > 0) ? $clog2(LEASE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((LEASE_CYCLES > 0) ? LEASE_CYCLES - 1 : 0);
  localparam logic [31:0]      A_RST_FLAG = 32'(NUM_MUTEX);
  localparam logic [31:0]      A_LOCKED   = 32'(NUM_MUTEX + 1);
  localparam logic [31:0]      A_IRQ_EN   = 32'(NUM_MUTEX + 2);
  localparam logic [31:0]      A_IRQ_PEND = 32'(NUM_MUTEX + 3);

  logic [15:0]          r_owner [NUM_MUTEX];
  logic [15:0]          r_value [NUM_MUTEX];
  logic [CNT_W-1:0]     r_cnt   [NUM_MUTEX];
  logic                 r_rst_flag;
  logic [NUM_MUTEX-1:0] r_irq_en;
  logic [NUM_MUTEX-1:0] r_irq_pend;
  logic                 r_irq;
  logic [31:0]          r_rdata;

  logic [31:0]          w_addr;
  logic                 w_wr;
  logic                 w_rd;
  logic [NUM_MUTEX-1:0] w_locked;
  logic [NUM_MUTEX-1:0] w_accept;
  logic [NUM_MUTEX-1:0] w_expire;
  logic [NUM_MUTEX-1:0] w_release;
  logic [NUM_MUTEX-1:0] w_pend_clr;
  logic [31:0]          w_rdata;

  always_comb begin
    w_addr     = 32'(address);
    w_wr       = chipselect & write;
    w_rd       = chipselect & read;
    w_rdata    = '0;
    w_locked   = '0;
    w_accept   = '0;
    w_expire   = '0;
    w_release  = '0;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      w_locked[i] = (r_value[i] != 16'h0000);
      // Free mutexes accept anyone; locked ones only their owner.
      w_accept[i] = w_wr && (w_addr == 32'(i)) &&
                    (!w_locked[i] || (r_owner[i] == data_from_cpu[31:16]));
      // An accepted write in the expiry cycle wins, so expiry excludes it.
      w_expire[i] = (LEASE_CYCLES > 0) && w_locked[i] && !w_accept[i] &&
                    (r_cnt[i] == CNT_LAST);
      w_release[i] = (w_accept[i] && w_locked[i] && (data_from_cpu[15:0] == 16'h0000)) ||
                     w_expire[i];
      if (w_addr == 32'(i)) begin
        w_rdata = {r_owner[i], r_value[i]};
      end
    end
    if (w_addr == A_RST_FLAG) begin
      w_rdata = {31'h0, r_rst_flag};
    end else if (w_addr == A_LOCKED) begin
      w_rdata = 32'(w_locked);
    end else if (w_addr == A_IRQ_EN) begin
      w_rdata = 32'(r_irq_en);
    end else if (w_addr == A_IRQ_PEND) begin
      w_rdata = 32'(r_irq_pend);
    end
    w_pend_clr = (w_wr && (w_addr == A_IRQ_PEND)) ? data_from_cpu[NUM_MUTEX-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_MUTEX; i++) begin
        r_owner[i] <= INIT_OWNER;
        r_value[i] <= INIT_VALUE;
        r_cnt[i]   <= '0;
      end
      r_rst_flag <= 1'b1;
      r_irq_en   <= '0;
      r_irq_pend <= '0;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      for (int i = 0; i < NUM_MUTEX; i++) begin
        if (w_accept[i]) begin
          r_owner[i] <= data_from_cpu[31:16];
          r_value[i] <= data_from_cpu[15:0];
          r_cnt[i]   <= '0;
        end else if (w_expire[i]) begin
          r_owner[i] <= 16'h0000;
          r_value[i] <= 16'h0000;
          r_cnt[i]   <= '0;
        end else if ((LEASE_CYCLES > 0) && w_locked[i]) begin
          r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
        end else begin
          r_cnt[i]   <= '0;
        end
      end
      if (w_wr && (w_addr == A_RST_FLAG)) begin
        r_rst_flag <= 1'b0;
      end
      if (w_wr && (w_addr == A_IRQ_EN)) begin
        r_irq_en <= data_from_cpu[NUM_MUTEX-1:0];
      end
      // Set wins over a simultaneous write-1-to-clear of the same bit.
      r_irq_pend <= (r_irq_pend & ~w_pend_clr) | w_release;
      r_irq      <= |(r_irq_pend & r_irq_en);
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign data_to_cpu = r_rdata;
  assign irq         = r_irq;

endmodule

// File: tb/tb_system_mutex_bank.sv
module tb_system_mutex_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] data_from_cpu = '0;
  logic [31:0] rd0, rd8;
  logic        irq0, irq8;

  // dut0: no lease, nonzero init owner; dut8: 8-cycle lease.
  system_mutex_bank #(.NUM_MUTEX(4), .ADDR_W(4), .LEASE_CYCLES(0),
                      .INIT_OWNER(16'h0055), .INIT_VALUE(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .data_from_cpu(data_from_cpu),
    .data_to_cpu(rd0), .irq(irq0));

  system_mutex_bank #(.NUM_MUTEX(4), .ADDR_W(4), .LEASE_CYCLES(8),
                      .INIT_OWNER(16'h0000), .INIT_VALUE(16'h0000)) dut8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .data_from_cpu(data_from_cpu),
    .data_to_cpu(rd8), .irq(irq8));

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Lease tracked as "edge number of last accepted write (or reset)".
  int          lease    [2] = '{0, 8};
  logic [15:0] init_own [2] = '{16'h0055, 16'h0000};
  logic [15:0] m_owner  [2][4];
  logic [15:0] m_value  [2][4];
  int          m_stamp  [2][4];
  logic        m_rst    [2];
  logic [3:0]  m_en     [2];
  logic [3:0]  m_pend   [2];
  logic        m_irq    [2];
  logic [31:0] m_rd     [2];
  int          edge_n = 0;

  task automatic model_edge(input bit rst, input bit cs, input bit rd, input bit wr,
                            input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rv;
    logic [3:0]  rel, clr, lk;
    logic        nirq;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_owner[k][i] = init_own[k];
          m_value[k][i] = 16'h0000;
          m_stamp[k][i] = edge_n;
        end
        m_rst[k] = 1'b1; m_en[k] = '0; m_pend[k] = '0; m_irq[k] = 1'b0; m_rd[k] = '0;
      end else begin
        for (int i = 0; i < 4; i++) lk[i] = (m_value[k][i] != 0);
        rv = '0;
        if (a < 4)       rv = {m_owner[k][a[1:0]], m_value[k][a[1:0]]};
        else if (a == 4) rv = {31'h0, m_rst[k]};
        else if (a == 5) rv = {28'h0, lk};
        else if (a == 6) rv = {28'h0, m_en[k]};
        else if (a == 7) rv = {28'h0, m_pend[k]};
        nirq = |(m_pend[k] & m_en[k]);
        rel = '0;
        for (int i = 0; i < 4; i++) begin
          if (cs && wr && a == i && (!lk[i] || m_owner[k][i] == d[31:16])) begin
            if (lk[i] && d[15:0] == 0) rel[i] = 1'b1;
            m_owner[k][i] = d[31:16];
            m_value[k][i] = d[15:0];
            m_stamp[k][i] = edge_n;
          end else if (lease[k] != 0 && lk[i] && (edge_n - m_stamp[k][i]) == lease[k]) begin
            m_owner[k][i] = 16'h0000;
            m_value[k][i] = 16'h0000;
            rel[i] = 1'b1;
          end
        end
        if (cs && wr && a == 4) m_rst[k] = 1'b0;
        if (cs && wr && a == 6) m_en[k] = d[3:0];
        clr = (cs && wr && a == 7) ? d[3:0] : 4'h0;
        m_pend[k] = (m_pend[k] & ~clr) | rel;
        m_irq[k] = nirq;
        if (cs && rd) m_rd[k] = rv;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit cs, input bit rd, input bit wr,
                      input logic [3:0] a, input logic [31:0] d);
    reset = rst; chipselect = cs; read = rd; write = wr; address = a; data_from_cpu = d;
    model_edge(rst, cs, rd, wr, a, d);
    exp_q.push_back(m_rd[0]);
    exp_q.push_back(m_rd[1]);
    @(posedge clk);
    #1;
    check("model_rd0", rd0, exp_q.pop_front());
    check("model_rd8", rd8, exp_q.pop_front());
    check("model_irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
    check("model_irq8", {31'h0, irq8}, {31'h0, m_irq[1]});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          cs, rd, wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1, 1, 0, 4'd4,  32'h0,        32'h00000001, 0};
    tbl[1]  = '{1, 1, 1, 4'd4,  32'h0,        32'h00000001, 0};
    tbl[2]  = '{1, 1, 0, 4'd4,  32'h0,        32'h00000000, 0};
    tbl[3]  = '{1, 1, 0, 4'd0,  32'h0,        32'h00550000, 0};
    tbl[4]  = '{1, 1, 0, 4'd15, 32'h0,        32'h00000000, 0};
    tbl[5]  = '{1, 0, 1, 4'd1,  32'h00AA0001, 32'h00000000, 0};
    tbl[6]  = '{1, 1, 1, 4'd1,  32'h00BB0001, 32'h00AA0001, 0};
    tbl[7]  = '{1, 1, 0, 4'd1,  32'h0,        32'h00AA0001, 0};
    tbl[8]  = '{1, 1, 0, 4'd5,  32'h0,        32'h00000002, 0};
    tbl[9]  = '{1, 0, 1, 4'd6,  32'hFFFFFFF2, 32'h00000002, 0};
    tbl[10] = '{1, 1, 0, 4'd6,  32'h0,        32'h00000002, 0};
    tbl[11] = '{1, 0, 1, 4'd1,  32'h00AA0000, 32'h00000002, 0};
    tbl[12] = '{1, 1, 0, 4'd7,  32'h0,        32'h00000002, 1};
    tbl[13] = '{1, 1, 0, 4'd5,  32'h0,        32'h00000000, 1};
    tbl[14] = '{1, 0, 1, 4'd7,  32'h00000002, 32'h00000000, 1};
    tbl[15] = '{1, 1, 0, 4'd7,  32'h0,        32'h00000000, 0};
    tbl[16] = '{1, 1, 0, 4'd6,  32'h0,        32'h00000002, 0};
    tbl[17] = '{0, 1, 1, 4'd1,  32'h00CC0001, 32'h00000002, 0};
    tbl[18] = '{1, 1, 0, 4'd1,  32'h0,        32'h00AA0000, 0};

    // Reset state.
    step(1, 0, 0, 0, 4'h0, 32'h0);
    check("reset_rd0", rd0, 32'h0);
    check("reset_irq0", {31'h0, irq0}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      step(0, tbl[i].cs, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_rd", i), rd0, tbl[i].exp_rd);
      check($sformatf("tbl%0d_irq", i), {31'h0, irq0}, {31'h0, tbl[i].exp_irq});
    end

    // Lease expiry: frees on the 8th edge after the write.
    step(1, 0, 0, 0, 4'h0, 32'h0);
    step(0, 1, 0, 1, 4'd0, 32'h00110005);
    for (int k = 1; k <= 9; k++) begin
      step(0, 1, 1, 0, 4'd0, 32'h0);
      check($sformatf("lease_k%0d", k), rd8, (k <= 8) ? 32'h00110005 : 32'h0);
    end
    step(0, 1, 1, 0, 4'd7, 32'h0);
    check("lease_pend", rd8, 32'h1);

    // Owner re-write on cycle 7 keeps it locked.
    step(1, 0, 0, 0, 4'h0, 32'h0);
    step(0, 1, 0, 1, 4'd0, 32'h00110005);
    for (int k = 1; k <= 6; k++) idle();
    step(0, 1, 0, 1, 4'd0, 32'h00110006);
    step(0, 1, 1, 0, 4'd0, 32'h0);
    step(0, 1, 1, 0, 4'd0, 32'h0);
    check("rewrite_held", rd8, 32'h00110006);

    // Owner write exactly on the expiry edge wins.
    step(1, 0, 0, 0, 4'h0, 32'h0);
    step(0, 1, 0, 1, 4'd0, 32'h00110005);
    for (int k = 1; k <= 7; k++) idle();
    step(0, 1, 0, 1, 4'd0, 32'h00110007);
    step(0, 1, 1, 0, 4'd0, 32'h0);
    check("collide_write_wins", rd8, 32'h00110007);
    step(0, 1, 1, 0, 4'd7, 32'h0);
    check("collide_no_pend", rd8, 32'h0);

    // Expiry release coincides with W1C of the same bit: bit stays set.
    step(1, 0, 0, 0, 4'h0, 32'h0);
    step(0, 1, 0, 1, 4'd0, 32'h00110005);
    for (int k = 1; k <= 7; k++) idle();
    step(0, 1, 0, 1, 4'd7, 32'h00000001);
    step(0, 1, 1, 0, 4'd7, 32'h0);
    check("set_wins_pend", rd8, 32'h1);

    // Reset mid-operation with 3 mutexes locked and irq high.
    step(1, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 4'(i), 32'h00010001);
    step(0, 1, 0, 1, 4'd6, 32'h0000000F);
    step(0, 1, 0, 1, 4'd3, 32'h00010000);
    idle();
    check("pre_reset_irq8", {31'h0, irq8}, 32'h1);
    check("pre_reset_irq0", {31'h0, irq0}, 32'h1);
    step(0, 1, 1, 0, 4'd5, 32'h0);
    step(1, 1, 1, 1, 4'd0, 32'h00020002);
    check("midrst_rd8", rd8, 32'h0);
    check("midrst_irq8", {31'h0, irq8}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      step(0, 1, 1, 0, 4'(a), 32'h0);
      check($sformatf("midrst_reg%0d_8", a), rd8, (a == 4) ? 32'h1 : 32'h0);
      check($sformatf("midrst_reg%0d_0", a), rd0,
            (a == 4) ? 32'h1 : ((a < 4) ? 32'h00550000 : 32'h0));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  ra;
      logic [31:0] rdat;
      ra = 4'($urandom_range(0, 8));
      if (ra == 8) ra = 4'($urandom_range(8, 15));
      rdat = {16'($urandom_range(1, 3)),
              ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 3))};
      if (ra >= 4 && ra <= 7) rdat = $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           $urandom_range(0, 1), $urandom_range(0, 1), ra, rdat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
